fifo_wr_arbiter: RTL and testbench

// - Shares the single write port of one async_fifo between NUM_CH producers in the wr_clk domain.
// - Round-robin, burst-locked arbitration with valid/ready handshakes; every accepted beat is written to the FIFO.
// - Each FIFO word is tagged {last, ch_id, data} so the rd_clk consumer can demultiplex.
// - Sits between the ADC/DSP channel sources and the CDC FIFO that feeds the USB/host side.

---
 rtl/sdr_fifo_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/fifo_wr_arbiter.sv | 136 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_fifo_pkg.sv
//------------------------------------------------------------------------------
// sdr_fifo_pkg
// Shared types, word layout and helpers for the CDC FIFO write-side arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package sdr_fifo_pkg;

  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_CH_W      = 2;
  localparam int DEF_DATA_W    = 29;
  localparam int DEF_FIFO_W    = 32;
  localparam int DEF_MAX_BURST = 16;
  localparam int DEF_IDLE_TO   = 8;

  localparam int LAST_BIT = DEF_FIFO_W - 1;
  localparam int CH_LSB   = DEF_DATA_W;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  function automatic logic [DEF_FIFO_W-1:0] pack_word(
    input logic                  last,
    input logic [DEF_CH_W-1:0]   ch,
    input logic [DEF_DATA_W-1:0] data
  );
    return {last, ch, data};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: first set request at or above ptr, with wrap.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);

  localparam logic [W:0] c_n = (W+1)'(N);

  logic [W:0]   w_sum;
  logic [W-1:0] w_idx;

  // Scan from the highest offset down so the lowest offset wins last.
  always_comb begin
    gnt_idx = ptr;
    gnt_vld = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, ptr} + (W+1)'(k);
      if (w_sum >= c_n) begin
        w_sum = w_sum - c_n;
      end
      w_idx = w_sum[W-1:0];
      if (req[w_idx]) begin
        gnt_idx = w_idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
//------------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin, burst-locked sharing of one async_fifo write port by NUM_CH sources.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fifo_wr_arbiter
  import sdr_fifo_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int CH_W      = DEF_CH_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FIFO_W    = DEF_FIFO_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int IDLE_TO   = DEF_IDLE_TO
) (
  input  logic                     wr_clk,
  input  logic                     wr_rst_n,
  input  logic                     cfg_enable,
  input  logic [NUM_CH-1:0]        cfg_ch_mask,
  input  logic [NUM_CH-1:0]        s_valid,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  input  logic [NUM_CH-1:0]        s_last,
  output logic [NUM_CH-1:0]        s_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [FIFO_W-1:0]        fifo_din,
  output logic                     busy,
  output logic [CH_W-1:0]          grant_ch,
  output logic [31:0]              word_count
);

  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam int TO_W   = $clog2(IDLE_TO + 1);

  localparam logic [BEAT_W-1:0] c_beat_last = BEAT_W'(MAX_BURST - 1);
  localparam logic [BEAT_W-1:0] c_beat_one  = BEAT_W'(1);
  localparam logic [TO_W-1:0]   c_to_last   = TO_W'(IDLE_TO - 1);
  localparam logic [TO_W-1:0]   c_to_one    = TO_W'(1);
  localparam logic [CH_W-1:0]   c_ch_max    = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0]   c_ch_one    = CH_W'(1);

  arb_state_e        r_state;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [CH_W-1:0]   r_grant_ch;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [31:0]       r_word_count;

  logic [NUM_CH-1:0] w_req;
  logic [CH_W-1:0]   w_arb_idx;
  logic              w_arb_vld;
  logic              w_burst;
  logic              w_g_valid;
  logic              w_g_last;
  logic [DATA_W-1:0] w_g_data;
  logic              w_xfer;
  logic              w_idle_cyc;
  logic              w_end;

  assign w_req = s_valid & cfg_ch_mask;

  rr_arbiter #(
    .N (NUM_CH),
    .W (CH_W)
  ) u_rr_arbiter (
    .req     (w_req),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_arb_idx),
    .gnt_vld (w_arb_vld)
  );

  assign w_burst    = (r_state == ARB_BURST);
  assign w_g_valid  = s_valid[r_grant_ch];
  assign w_g_last   = s_last[r_grant_ch];
  assign w_g_data   = s_data[r_grant_ch*DATA_W +: DATA_W];
  assign w_xfer     = w_burst & w_g_valid & ~fifo_full;
  assign w_idle_cyc = w_burst & ~w_g_valid & ~fifo_full;

  // Any combination of end conditions collapses into one exit.
  assign w_end = (w_xfer & (w_g_last | (r_beat_cnt == c_beat_last)))
               | (w_idle_cyc & (r_to_cnt == c_to_last));

  always_comb begin
    s_ready = '0;
    if (w_burst && !fifo_full) begin
      s_ready[r_grant_ch] = 1'b1;
    end
  end

  assign fifo_wr_en = w_xfer;
  assign fifo_din   = {w_g_last, r_grant_ch, w_g_data};
  assign busy       = w_burst;
  assign grant_ch   = r_grant_ch;
  assign word_count = r_word_count;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_state      <= ARB_IDLE;
      r_rr_ptr     <= '0;
      r_grant_ch   <= '0;
      r_beat_cnt   <= '0;
      r_to_cnt     <= '0;
      r_word_count <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (cfg_enable && w_arb_vld) begin
            r_grant_ch <= w_arb_idx;
            r_state    <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          if (w_xfer) begin
            r_word_count <= r_word_count + 32'd1;
            r_beat_cnt   <= r_beat_cnt + c_beat_one;
            r_to_cnt     <= '0;
          end else if (w_idle_cyc) begin
            r_to_cnt <= r_to_cnt + c_to_one;
          end
          if (w_end) begin
            r_state    <= ARB_IDLE;
            r_rr_ptr   <= (r_grant_ch == c_ch_max) ? '0 : r_grant_ch + c_ch_one;
            r_beat_cnt <= '0;
            r_to_cnt   <= '0;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
//------------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Randomized sources and backpressure against a transaction-level arbiter model.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_wr_arbiter;
  import sdr_fifo_pkg::*;

  localparam int NUM_CH    = 4;
  localparam int CH_W      = 2;
  localparam int DATA_W    = 29;
  localparam int FIFO_W    = 32;
  localparam int MAX_BURST = 16;
  localparam int IDLE_TO   = 8;
  localparam int N_CYCLES  = 6000;

  logic                     wr_clk      = 1'b0;
  logic                     wr_rst_n    = 1'b0;
  logic                     cfg_enable  = 1'b0;
  logic [NUM_CH-1:0]        cfg_ch_mask = '0;
  logic [NUM_CH-1:0]        s_valid     = '0;
  logic [NUM_CH*DATA_W-1:0] s_data      = '0;
  logic [NUM_CH-1:0]        s_last      = '0;
  logic [NUM_CH-1:0]        s_ready;
  logic                     fifo_full   = 1'b0;
  logic                     fifo_wr_en;
  logic [FIFO_W-1:0]        fifo_din;
  logic                     busy;
  logic [CH_W-1:0]          grant_ch;
  logic [31:0]              word_count;

  fifo_wr_arbiter #(
    .NUM_CH    (NUM_CH),
    .CH_W      (CH_W),
    .DATA_W    (DATA_W),
    .FIFO_W    (FIFO_W),
    .MAX_BURST (MAX_BURST),
    .IDLE_TO   (IDLE_TO)
  ) dut (
    .wr_clk      (wr_clk),
    .wr_rst_n    (wr_rst_n),
    .cfg_enable  (cfg_enable),
    .cfg_ch_mask (cfg_ch_mask),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_din    (fifo_din),
    .busy        (busy),
    .grant_ch    (grant_ch),
    .word_count  (word_count)
  );

  always #5 wr_clk = ~wr_clk;

  // Per-channel scoreboard: every beat offered by a source, in order.
  logic [FIFO_W-1:0] exp_q [NUM_CH][$];
  int n_cmp = 0;
  int n_err = 0;
  int n_writes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor with a transaction-level model of the arbitration rules.
  initial begin
    int   m_busy, m_g, m_ptr, m_beats, m_idle, ch, pick;
    logic [31:0]       m_wc;
    logic [NUM_CH-1:0] req, exp_rdy;
    logic              g_valid, xfer, ended;
    logic [FIFO_W-1:0] want;
    m_busy = 0; m_g = 0; m_ptr = 0; m_beats = 0; m_idle = 0; m_wc = '0;
    forever begin
      @(negedge wr_clk);
      if (!wr_rst_n) begin
        check("rst_s_ready",    64'(s_ready),    64'(0));
        check("rst_fifo_wr_en", 64'(fifo_wr_en), 64'(0));
        check("rst_busy",       64'(busy),       64'(0));
        check("rst_grant_ch",   64'(grant_ch),   64'(0));
        check("rst_word_count", 64'(word_count), 64'(0));
        m_busy = 0; m_g = 0; m_ptr = 0; m_beats = 0; m_idle = 0; m_wc = '0;
        continue;
      end
      g_valid = s_valid[m_g];
      xfer    = (m_busy != 0) && g_valid && !fifo_full;
      exp_rdy = ((m_busy != 0) && !fifo_full) ? (NUM_CH'(1) << m_g) : '0;
      check("busy",       64'(busy),       64'(m_busy));
      check("s_ready",    64'(s_ready),    64'(exp_rdy));
      check("fifo_wr_en", 64'(fifo_wr_en), 64'(xfer));
      check("word_count", 64'(word_count), 64'(m_wc));
      if (m_busy != 0) check("grant_ch", 64'(grant_ch), 64'(m_g));
      if (fifo_wr_en) begin
        n_writes++;
        ch = int'(fifo_din[CH_LSB +: CH_W]);
        check("fifo_ch_field", 64'(ch), 64'(m_g));
        check("beat_pending", 64'(exp_q[ch].size() > 0), 64'(1));
        if (exp_q[ch].size() > 0) begin
          want = exp_q[ch].pop_front();
          check("fifo_din", 64'(fifo_din), 64'(want));
        end
      end
      if (m_busy != 0) begin
        ended = 1'b0;
        if (xfer) begin
          m_wc++;
          m_beats++;
          m_idle = 0;
          ended = s_last[m_g] || (m_beats == MAX_BURST);
        end else if (!g_valid && !fifo_full) begin
          m_idle++;
          ended = (m_idle == IDLE_TO);
        end
        if (ended) begin
          m_busy = 0; m_ptr = (m_g + 1) % NUM_CH; m_beats = 0; m_idle = 0;
        end
      end else begin
        req = s_valid & cfg_ch_mask;
        if (cfg_enable && req != '0) begin
          pick = -1;
          for (int k = 0; k < NUM_CH; k++) begin
            if (pick < 0 && req[(m_ptr + k) % NUM_CH]) pick = (m_ptr + k) % NUM_CH;
          end
          m_g = pick;
          m_busy = 1;
        end
      end
    end
  end

  // Stimulus: packetised sources with gaps, random FIFO backpressure, config phases.
  initial begin
    logic [NUM_CH-1:0] xfer, pending;
    int                rem [NUM_CH];
    int                gap [NUM_CH];
    int                full_hold, rst_hold, seg;
    logic              want_reset, cur_last;
    logic [DATA_W-1:0] cur_data;
    pending = '0; full_hold = 0; rst_hold = 0; want_reset = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin rem[i] = 0; gap[i] = 0; end
    cfg_enable = 1'b1;
    cfg_ch_mask = '1;
    wr_rst_n = 1'b0;
    repeat (3) @(posedge wr_clk);
    #1 wr_rst_n = 1'b1;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge wr_clk);
      xfer = s_valid & s_ready;
      @(posedge wr_clk);
      #1;
      for (int i = 0; i < NUM_CH; i++) if (xfer[i]) pending[i] = 1'b0;

      if (cyc % 250 == 0) begin
        seg = (cyc / 250) % 6;
        cfg_enable = 1'b1;
        case (seg)
          1:       cfg_ch_mask = 4'b1010;
          2:       cfg_ch_mask = NUM_CH'($urandom);
          default: cfg_ch_mask = '1;
        endcase
      end
      if (cyc % 250 == 125 && $urandom_range(0, 2) == 0) cfg_enable = 1'b0;
      if (cyc == 2000 || cyc == 4000) want_reset = 1'b1;

      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) wr_rst_n = 1'b1;
        continue;
      end
      if (want_reset && busy) begin
        want_reset = 1'b0;
        wr_rst_n   = 1'b0;
        rst_hold   = 2;
        s_valid    = '0;
        pending    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
          exp_q[i].delete();
          rem[i] = 0;
          gap[i] = 0;
        end
        continue;
      end

      for (int i = 0; i < NUM_CH; i++) begin
        if (gap[i] > 0) gap[i]--;
        if (!pending[i] && $urandom_range(0, 3) != 0) begin
          if (rem[i] == 0) rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(17, 24) : $urandom_range(1, 6);
          cur_last = (rem[i] == 1);
          rem[i]--;
          cur_data = DATA_W'($urandom);
          s_data[i*DATA_W +: DATA_W] = cur_data;
          s_last[i] = cur_last;
          exp_q[i].push_back(pack_word(cur_last, CH_W'(i), cur_data));
          pending[i] = 1'b1;
          if ($urandom_range(0, 19) == 0) gap[i] = $urandom_range(4, 12);
        end
        s_valid[i] = pending[i] && (gap[i] == 0) && ($urandom_range(0, 9) != 0);
      end

      if (full_hold == 0 && $urandom_range(0, 15) == 0) full_hold = $urandom_range(1, 6);
      fifo_full = (full_hold > 0);
      if (full_hold > 0) full_hold--;
    end

    @(negedge wr_clk);
    xfer = s_valid & s_ready;
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) if (xfer[i]) pending[i] = 1'b0;
    s_valid = '0;
    fifo_full = 1'b0;
    repeat (3) @(negedge wr_clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("leftover_beats_ch%0d", i), 64'(exp_q[i].size()), 64'(pending[i]));
    end
    check("enough_writes", 64'(n_writes > 500), 64'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
